fifo_tx_drain: RTL

//  Read-side companion of the byte-granular width-converting FIFO. Drains FIFO words through its

---
 rtl/fifo_tx_drain_pkg.sv | 22 ++
 rtl/fifo_tx_drain_hw_ser.sv | 50 +++++
 rtl/fifo_tx_drain.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_tx_drain_pkg.sv
// Shared definitions for the FIFO-to-1553B transmit drain.
//   state_t        : drain FSM state encodings
//   TX_WORD_W      : 1553B data word width
//   MAX_MSG_WORDS  : longest message (word_cnt==0 encodes this)
//   msg_len()      : maps the 5-bit word_cnt field onto a 6-bit word count
package fifo_tx_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int TX_WORD_W     = 16;
  localparam int MAX_MSG_WORDS = 32;
  localparam int WCNT_W        = 6;

  function automatic logic [WCNT_W-1:0] msg_len(input logic [4:0] word_cnt);
    return (word_cnt == 5'd0) ? WCNT_W'(MAX_MSG_WORDS) : {1'b0, word_cnt};
  endfunction

endpackage

// File: rtl/fifo_tx_drain_hw_ser.sv
// tx_hw_serializer: holds one FIFO word and presents it a halfword at a time,
// lowest halfword first.
//   clk, rst_n : clock, async active-low reset
//   load, din  : capture a new FIFO word, index back to halfword 0
//   adv        : step to the next halfword (wraps after the last one)
//   clr        : zero the hold register and index
//   hw_data    : current halfword
//   hw_last    : current halfword is the top one of the word
module tx_hw_serializer
  import fifo_tx_drain_pkg::*;
#(
  parameter int DW_R = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 adv,
  input  logic                 clr,
  input  logic [DW_R-1:0]      din,
  output logic [TX_WORD_W-1:0] hw_data,
  output logic                 hw_last
);

  localparam int HW = DW_R / TX_WORD_W;
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;

  logic [HW-1:0][TX_WORD_W-1:0] hold;
  logic [IW-1:0]                idx;

  assign hw_last = (idx == IW'(HW - 1));
  assign hw_data = hold[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx  <= '0;
    end else if (clr) begin
      hold <= '0;
      idx  <= '0;
    end else if (load) begin
      hold <= din;
      idx  <= '0;
    end else if (adv) begin
      // wrap instead of running past the top halfword so the mux never
      // selects outside the hold register
      idx <= hw_last ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain: pops words from a show-ahead FIFO and streams them to the
// 1553B encoder as 16-bit words over valid/ready.
//   clk, rst_n      : clock, async active-low reset
//   start, word_cnt : begin a message of word_cnt words (0 = 32), IDLE only
//   abort           : drop the current message, back to IDLE
//   fifo_empty/data : show-ahead FIFO head; fifo_rd pops it
//   tx_data/valid/ready/last : encoder handshake
//   busy            : not IDLE
//   done            : pulse after the last word is accepted
//   err_underrun    : pulse when the FIFO stays empty too long in LOAD
//   words_sent      : words accepted in the current/last message
module fifo_tx_drain
  import fifo_tx_drain_pkg::*;
#(
  parameter int DW_R        = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      word_cnt,
  input  logic            abort,
  input  logic            fifo_empty,
  input  logic [DW_R-1:0] fifo_data,
  output logic            fifo_rd,
  output logic [15:0]     tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            tx_last,
  output logic            busy,
  output logic            done,
  output logic            err_underrun,
  output logic [5:0]      words_sent
);

  // the counter advances to TIMEOUT_CYC-1 on the edge that aborts, so the
  // decision is taken while it still holds TIMEOUT_CYC-2
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 2);

  state_t            state, state_nxt;
  logic [5:0]        remaining;
  logic [TO_W-1:0]   to_cnt;
  logic              start_go, ld, adv, acc, to_fire, fin;
  logic              hw_last;

  tx_hw_serializer #(.DW_R(DW_R)) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ld),
    .adv     (adv),
    .clr     (start_go),
    .din     (fifo_data),
    .hw_data (tx_data),
    .hw_last (hw_last)
  );

  assign busy     = (state != ST_IDLE);
  assign tx_valid = (state == ST_SEND);
  assign tx_last  = tx_valid && (remaining == 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    fifo_rd   = 1'b0;
    ld        = 1'b0;
    adv       = 1'b0;
    acc       = 1'b0;
    to_fire   = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          start_go  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          ld        = 1'b1;
          state_nxt = ST_SEND;
        end else if (to_cnt == TO_LIM) begin
          to_fire   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (tx_ready) begin
          acc = 1'b1;
          adv = 1'b1;
          if (remaining == 6'd1) begin
            // leftover halfwords are dropped; the word is already popped
            fin       = 1'b1;
            state_nxt = ST_IDLE;
          end else if (hw_last) begin
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining    <= '0;
      words_sent   <= '0;
      to_cnt       <= '0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      done         <= fin;
      err_underrun <= to_fire;
      if (start_go) begin
        remaining  <= msg_len(word_cnt);
        words_sent <= '0;
      end else if (acc) begin
        remaining  <= remaining - 6'd1;
        words_sent <= words_sent + 6'd1;
      end
      // any state other than LOAD zeroes the counter, so every entry starts fresh
      if (state != ST_LOAD)         to_cnt <= '0;
      else if (fifo_empty && !abort) to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule
